// File: rtl/data_mem_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// dmem_arb_pkg
// Shared types and constants for the data-memory arbiter: the arbiter state
// encoding, requester IDs and the one-hot owner encodings reported on the
// owner output.
// ---------------------------------------------------------------------------
package dmem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } arb_state_e;

  // Requester IDs: 0 is the CPU load/store stage, 1 the NN layer engine.
  localparam logic REQ_CPU = 1'b0;
  localparam logic REQ_NN  = 1'b1;

  localparam logic [1:0] OWNER_NONE = 2'b00;
  localparam logic [1:0] OWNER_CPU  = 2'b01;
  localparam logic [1:0] OWNER_NN   = 2'b10;

  function automatic logic [1:0] owner_of(arb_state_e st);
    logic [1:0] oh;
    oh = OWNER_NONE;
    case (st)
      OWN0:    oh = OWNER_CPU;
      OWN1:    oh = OWNER_NN;
      default: oh = OWNER_NONE;
    endcase
    return oh;
  endfunction

endpackage

// File: rtl/data_mem_arbiter_if.sv
// ---------------------------------------------------------------------------
// data_mem_arbiter_if
// Bundles both requester channels and the memory-side bus of the arbiter.
//   req*  : request valid / write-enable / address / write data / last beat
//   reqAck: beat accepted (combinational from the arbiter)
//   rsp*  : registered read response per requester
//   mem*  : single-port memory address, write data/enable, read data
//   owner : one-hot current owner, busy : arbiter not idle
// Modports: slave = arbiter side, master = requesters + memory side.
// ---------------------------------------------------------------------------
interface data_mem_arbiter_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);

  logic                  reqV0,     reqV1;
  logic                  reqWe0,    reqWe1;
  logic [ADDR_WIDTH-1:0] reqAddr0,  reqAddr1;
  logic [DATA_WIDTH-1:0] reqWData0, reqWData1;
  logic                  reqLast0,  reqLast1;
  logic                  reqAck0,   reqAck1;
  logic                  rspV0,     rspV1;
  logic [DATA_WIDTH-1:0] rspData0,  rspData1;

  logic                  memWriteEn;
  logic [ADDR_WIDTH-1:0] memAddr;
  logic [DATA_WIDTH-1:0] memWriteData;
  logic [DATA_WIDTH-1:0] memReadData;

  logic [1:0]            owner;
  logic                  busy;

  modport slave (
    input  reqV0, reqV1, reqWe0, reqWe1, reqAddr0, reqAddr1,
           reqWData0, reqWData1, reqLast0, reqLast1, memReadData,
    output reqAck0, reqAck1, rspV0, rspV1, rspData0, rspData1,
           memWriteEn, memAddr, memWriteData, owner, busy
  );

  modport master (
    output reqV0, reqV1, reqWe0, reqWe1, reqAddr0, reqAddr1,
           reqWData0, reqWData1, reqLast0, reqLast1, memReadData,
    input  reqAck0, reqAck1, rspV0, rspV1, rspData0, rspData1,
           memWriteEn, memAddr, memWriteData, owner, busy
  );

endinterface

// File: rtl/data_mem_arbiter_tenure_counter.sv
// ---------------------------------------------------------------------------
// arb_tenure_counter
// Per-tenure beat and idle counters for the data-memory arbiter.
//   clk_i, rst_ni  : clock, asynchronous active-low reset
//   clr_i          : clear both counters (tenure change / idle arbiter)
//   beat_i         : owner had a beat accepted this cycle
//   idle_i         : owner cycle without a request
//   cap_hit_o      : this accepted beat brings the beat count to MAX_BURST
//   timeout_hit_o  : this idle cycle brings the idle count to IDLE_TIMEOUT
// ---------------------------------------------------------------------------
module arb_tenure_counter #(
  parameter int MAX_BURST    = 16,
  parameter int IDLE_TIMEOUT = 4
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clr_i,
  input  logic beat_i,
  input  logic idle_i,
  output logic cap_hit_o,
  output logic timeout_hit_o
);

  localparam int BW = $clog2(MAX_BURST + 1);
  localparam int IW = $clog2(IDLE_TIMEOUT + 1);
  localparam logic [BW-1:0] BEAT_MAX  = BW'(MAX_BURST);
  localparam logic [BW-1:0] BEAT_LAST = BW'(MAX_BURST - 1);
  localparam logic [IW-1:0] IDLE_MAX  = IW'(IDLE_TIMEOUT);
  localparam logic [IW-1:0] IDLE_LAST = IW'(IDLE_TIMEOUT - 1);

  logic [BW-1:0] beat_cnt_q, beat_cnt_d;
  logic [IW-1:0] idle_cnt_q, idle_cnt_d;

  // The beat count saturates: an uncontended burst may run past MAX_BURST,
  // and any later contention must still see the cap as already reached.
  assign cap_hit_o     = beat_i & (beat_cnt_q >= BEAT_LAST);
  assign timeout_hit_o = idle_i & (idle_cnt_q == IDLE_LAST);

  always_comb begin
    beat_cnt_d = beat_cnt_q;
    idle_cnt_d = idle_cnt_q;
    if (clr_i) begin
      beat_cnt_d = '0;
      idle_cnt_d = '0;
    end else if (beat_i) begin
      idle_cnt_d = '0;
      if (beat_cnt_q != BEAT_MAX) beat_cnt_d = beat_cnt_q + BW'(1);
    end else if (idle_i) begin
      if (idle_cnt_q != IDLE_MAX) idle_cnt_d = idle_cnt_q + IW'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      beat_cnt_q <= '0;
      idle_cnt_q <= '0;
    end else begin
      beat_cnt_q <= beat_cnt_d;
      idle_cnt_q <= idle_cnt_d;
    end
  end

endmodule

// File: rtl/data_mem_arbiter.sv
// ---------------------------------------------------------------------------
// data_mem_arbiter
// Shares a single-port data memory between the CPU load/store stage
// (requester 0) and the NN layer engine (requester 1). Provides locked
// bursts with a beat cap under contention, an idle-release timeout and
// round-robin fairness. Memory reads are combinational, writes synchronous;
// read data is registered back to the requester one cycle after the ack.
//   CLK, RSTn : clock, asynchronous active-low reset
//   bus       : requester channels, memory bus, owner/busy status (slave)
// ---------------------------------------------------------------------------
module data_mem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int ADDR_WIDTH   = 32,
  parameter int DATA_WIDTH   = 32,
  parameter int MAX_BURST    = 16,
  parameter int IDLE_TIMEOUT = 4
) (
  input  logic             CLK,
  input  logic             RSTn,
  data_mem_arbiter_if.slave bus
);

  arb_state_e state_q, state_d;
  logic       last_owner_q, last_owner_d;

  logic                  rsp0_v_q, rsp0_v_d, rsp1_v_q, rsp1_v_d;
  logic [DATA_WIDTH-1:0] rsp0_data_q, rsp0_data_d, rsp1_data_q, rsp1_data_d;

  logic                  ack0, ack1;
  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_wdata;

  logic beat_acc, idle_cyc, last_acc, other_v;
  logic cap_hit, timeout_hit, tenure_end, cnt_clr;

  // Datapath mux: every memory-side signal is selected purely by state, so
  // in IDLE (and throughout reset) nothing reaches the memory.
  always_comb begin
    ack0      = 1'b0;
    ack1      = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    beat_acc  = 1'b0;
    idle_cyc  = 1'b0;
    last_acc  = 1'b0;
    other_v   = 1'b0;
    case (state_q)
      OWN0: begin
        ack0      = bus.reqV0;
        mem_we    = bus.reqV0 & bus.reqWe0;
        mem_addr  = bus.reqAddr0;
        mem_wdata = bus.reqWData0;
        beat_acc  = bus.reqV0;
        idle_cyc  = ~bus.reqV0;
        last_acc  = bus.reqV0 & bus.reqLast0;
        other_v   = bus.reqV1;
      end
      OWN1: begin
        ack1      = bus.reqV1;
        mem_we    = bus.reqV1 & bus.reqWe1;
        mem_addr  = bus.reqAddr1;
        mem_wdata = bus.reqWData1;
        beat_acc  = bus.reqV1;
        idle_cyc  = ~bus.reqV1;
        last_acc  = bus.reqV1 & bus.reqLast1;
        other_v   = bus.reqV0;
      end
      default: ;
    endcase
  end

  // The beat cap only forces a release when the other side is waiting.
  assign tenure_end = last_acc | (cap_hit & other_v) | timeout_hit;
  assign cnt_clr    = (state_q == IDLE) | tenure_end;

  arb_tenure_counter #(
    .MAX_BURST    (MAX_BURST),
    .IDLE_TIMEOUT (IDLE_TIMEOUT)
  ) u_tenure_cnt (
    .clk_i         (CLK),
    .rst_ni        (RSTn),
    .clr_i         (cnt_clr),
    .beat_i        (beat_acc),
    .idle_i        (idle_cyc),
    .cap_hit_o     (cap_hit),
    .timeout_hit_o (timeout_hit)
  );

  // Next-state: IDLE costs one arbitration cycle; a tenure that ends with the
  // other requester waiting hands over directly without a bubble.
  always_comb begin
    state_d      = state_q;
    last_owner_d = last_owner_q;
    case (state_q)
      IDLE: begin
        if (bus.reqV0 && bus.reqV1)
          state_d = (last_owner_q == REQ_CPU) ? OWN1 : OWN0;
        else if (bus.reqV0)
          state_d = OWN0;
        else if (bus.reqV1)
          state_d = OWN1;
      end
      OWN0: begin
        if (tenure_end) begin
          last_owner_d = REQ_CPU;
          state_d      = bus.reqV1 ? OWN1 : IDLE;
        end
      end
      OWN1: begin
        if (tenure_end) begin
          last_owner_d = REQ_NN;
          state_d      = bus.reqV0 ? OWN0 : IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Read responses: capture the combinational read data of an accepted read
  // beat; the data register holds its value between responses.
  always_comb begin
    rsp0_v_d    = ack0 & ~bus.reqWe0;
    rsp1_v_d    = ack1 & ~bus.reqWe1;
    rsp0_data_d = rsp0_v_d ? bus.memReadData : rsp0_data_q;
    rsp1_data_d = rsp1_v_d ? bus.memReadData : rsp1_data_q;
  end

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      state_q      <= IDLE;
      last_owner_q <= REQ_NN;
      rsp0_v_q     <= 1'b0;
      rsp1_v_q     <= 1'b0;
      rsp0_data_q  <= '0;
      rsp1_data_q  <= '0;
    end else begin
      state_q      <= state_d;
      last_owner_q <= last_owner_d;
      rsp0_v_q     <= rsp0_v_d;
      rsp1_v_q     <= rsp1_v_d;
      rsp0_data_q  <= rsp0_data_d;
      rsp1_data_q  <= rsp1_data_d;
    end
  end

  assign bus.reqAck0      = ack0;
  assign bus.reqAck1      = ack1;
  assign bus.memWriteEn   = mem_we;
  assign bus.memAddr      = mem_addr;
  assign bus.memWriteData = mem_wdata;
  assign bus.rspV0        = rsp0_v_q;
  assign bus.rspV1        = rsp1_v_q;
  assign bus.rspData0     = rsp0_data_q;
  assign bus.rspData1     = rsp1_data_q;
  assign bus.owner        = owner_of(state_q);
  assign bus.busy         = (state_q != IDLE);

endmodule

// File: tb/tb_data_mem_arbiter.sv
module tb_data_mem_arbiter;
  localparam int AW = 32, DW = 32, MAXB = 16, IDLE_TO = 4;

  logic CLK = 1'b0;
  logic RSTn;
  always #5 CLK = ~CLK;

  data_mem_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus();

  data_mem_arbiter #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MAX_BURST(MAXB), .IDLE_TIMEOUT(IDLE_TO)
  ) dut (
    .CLK  (CLK),
    .RSTn (RSTn),
    .bus  (bus)
  );

  typedef struct {
    logic        we;
    logic [7:0]  addr;
    logic [31:0] wd;
    logic        last;
    int          gap;
  } beat_t;

  int checks = 0;
  int errors = 0;

  // Environment memory (written by the DUT) and reference memory (model).
  logic [DW-1:0] mem     [256];
  logic [DW-1:0] ref_mem [256];
  assign bus.memReadData = mem[bus.memAddr[7:0]];

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 32'hC0DE0000 + i;
    mem[16] = 32'hDEADBEEF;
    forever begin
      @(posedge CLK);
      if (bus.memWriteEn) mem[bus.memAddr[7:0]] <= bus.memWriteData;
    end
  end

  beat_t       bq [2][$];
  logic [31:0] exp_q [2][$];
  logic        pend_v [2];
  logic [31:0] pend_d [2];
  logic        got_ack [2];

  logic        v [2], we [2], lst [2];
  logic [31:0] addr [2], wd [2];

  // Reference model state: owner (-1 = none), last owner, tenure counters.
  int m_own, m_last, m_beat, m_idle;

  int cap_cnt;
  bit cap_phase, seen0;

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: every read accepted last cycle must respond now with the data.
  initial begin
    forever begin
      @(negedge CLK);
      if (RSTn === 1'b1) begin
        if (bus.rspV0 === 1'b1) begin
          if (exp_q[0].size() == 0) begin
            checks++; errors++;
            $display("FAIL rsp0_unexpected got %0h expected none", bus.rspData0);
          end else chk("rspData0", bus.rspData0, exp_q[0].pop_front());
        end else if (exp_q[0].size() != 0) begin
          chk("rspV0", bus.rspV0, 1'b1);
          void'(exp_q[0].pop_front());
        end
        if (bus.rspV1 === 1'b1) begin
          if (exp_q[1].size() == 0) begin
            checks++; errors++;
            $display("FAIL rsp1_unexpected got %0h expected none", bus.rspData1);
          end else chk("rspData1", bus.rspData1, exp_q[1].pop_front());
        end else if (exp_q[1].size() != 0) begin
          chk("rspV1", bus.rspV1, 1'b1);
          void'(exp_q[1].pop_front());
        end
      end
    end
  end

  task automatic drive();
    for (int x = 0; x < 2; x++) begin
      if (bq[x].size() > 0 && bq[x][0].gap == 0) begin
        v[x] = 1'b1; we[x] = bq[x][0].we; addr[x] = {24'd0, bq[x][0].addr};
        wd[x] = bq[x][0].wd; lst[x] = bq[x][0].last;
      end else begin
        v[x] = 1'b0; we[x] = 1'b0; addr[x] = '0; wd[x] = '0; lst[x] = 1'b0;
      end
    end
    bus.reqV0 = v[0]; bus.reqWe0 = we[0]; bus.reqAddr0 = addr[0];
    bus.reqWData0 = wd[0]; bus.reqLast0 = lst[0];
    bus.reqV1 = v[1]; bus.reqWe1 = we[1]; bus.reqAddr1 = addr[1];
    bus.reqWData1 = wd[1]; bus.reqLast1 = lst[1];
  endtask

  task automatic model_check();
    logic e_ack [2];
    logic [1:0] e_owner;
    logic e_we;
    int o;
    bit fin;
    for (int x = 0; x < 2; x++) e_ack[x] = (m_own == x) && v[x];
    e_owner = (m_own == -1) ? 2'b00 : (m_own == 0 ? 2'b01 : 2'b10);
    e_we = (m_own >= 0) && v[m_own] && we[m_own];
    chk("reqAck0", bus.reqAck0, e_ack[0]);
    chk("reqAck1", bus.reqAck1, e_ack[1]);
    chk("owner", bus.owner, e_owner);
    chk("busy", bus.busy, m_own != -1);
    chk("memWriteEn", bus.memWriteEn, e_we);
    if (m_own >= 0 && v[m_own]) chk("memAddr", bus.memAddr, addr[m_own]);
    if (e_we) chk("memWriteData", bus.memWriteData, wd[m_own]);
    got_ack[0] = bus.reqAck0; got_ack[1] = bus.reqAck1;
    if (cap_phase) begin
      if (bus.reqAck0) seen0 = 1'b1;
      else if (!seen0 && bus.reqAck1) cap_cnt++;
    end
    for (int x = 0; x < 2; x++) begin
      pend_v[x] = 1'b0;
      if (e_ack[x]) begin
        if (we[x]) ref_mem[addr[x][7:0]] = wd[x];
        else begin pend_v[x] = 1'b1; pend_d[x] = ref_mem[addr[x][7:0]]; end
      end
    end
    if (m_own == -1) begin
      if (v[0] && v[1]) m_own = 1 - m_last;
      else if (v[0]) m_own = 0;
      else if (v[1]) m_own = 1;
      m_beat = 0; m_idle = 0;
    end else begin
      o = 1 - m_own;
      if (v[m_own]) begin m_beat++; m_idle = 0; end
      else m_idle++;
      fin = (v[m_own] && lst[m_own]) || (v[m_own] && m_beat >= MAXB && v[o])
            || (m_idle >= IDLE_TO);
      if (fin) begin
        m_last = m_own;
        m_own  = v[o] ? o : -1;
        m_beat = 0; m_idle = 0;
      end
    end
  endtask

  task automatic advance();
    beat_t b;
    for (int x = 0; x < 2; x++) begin
      if (pend_v[x]) exp_q[x].push_back(pend_d[x]);
      pend_v[x] = 1'b0;
      if (bq[x].size() > 0) begin
        if (bq[x][0].gap > 0) begin
          b = bq[x][0]; b.gap--; bq[x][0] = b;
        end else if (got_ack[x]) void'(bq[x].pop_front());
      end
    end
  endtask

  task automatic step();
    drive();
    @(negedge CLK);
    model_check();
    @(posedge CLK);
    #1;
    advance();
  endtask

  task automatic run_until_idle(int bound, int tail);
    int n = 0;
    while ((bq[0].size() != 0 || bq[1].size() != 0 || m_own != -1) && n < bound) begin
      step(); n++;
    end
    if (n >= bound) begin
      checks++; errors++;
      $display("FAIL drain_timeout got %0d cycles expected < %0d", n, bound);
    end
    repeat (tail) step();
  endtask

  task automatic push(int x, logic w, logic [7:0] a, logic [31:0] d, logic l, int g);
    beat_t b;
    b.we = w; b.addr = a; b.wd = d; b.last = l; b.gap = g;
    bq[x].push_back(b);
  endtask

  task automatic model_reset();
    m_own = -1; m_last = 1; m_beat = 0; m_idle = 0;
    for (int x = 0; x < 2; x++) begin
      bq[x].delete(); exp_q[x].delete(); pend_v[x] = 1'b0; got_ack[x] = 1'b0;
    end
  endtask

  initial begin
    int n;
    for (int i = 0; i < 256; i++) ref_mem[i] = 32'hC0DE0000 + i;
    ref_mem[16] = 32'hDEADBEEF;
    cap_phase = 1'b0; seen0 = 1'b0; cap_cnt = 0;
    model_reset();
    RSTn = 1'b0;
    drive();
    #1;
    chk("rst_owner", bus.owner, 2'b00);
    chk("rst_busy", bus.busy, 1'b0);
    chk("rst_memWriteEn", bus.memWriteEn, 1'b0);
    chk("rst_rspV0", bus.rspV0, 1'b0);
    chk("rst_rspV1", bus.rspV1, 1'b0);
    chk("rst_rspData0", bus.rspData0, 32'd0);
    repeat (2) @(posedge CLK);
    #1 RSTn = 1'b1;

    // Single read of a preloaded word.
    push(0, 1'b0, 8'h10, 32'd0, 1'b1, 0);
    run_until_idle(50, 3);

    // Simultaneous single beats, then a repeat.
    push(0, 1'b0, 8'h01, 32'd0, 1'b1, 0);
    push(1, 1'b0, 8'h02, 32'd0, 1'b1, 0);
    run_until_idle(50, 2);
    push(0, 1'b0, 8'h03, 32'd0, 1'b1, 0);
    push(1, 1'b0, 8'h04, 32'd0, 1'b1, 0);
    run_until_idle(50, 2);

    // Beat cap: 20-beat read burst from requester 1, requester 0 joins late.
    for (int i = 0; i < 20; i++) push(1, 1'b0, 8'(8'h40 + i), 32'd0, i == 19, 0);
    push(0, 1'b0, 8'h05, 32'd0, 1'b0, 4);
    push(0, 1'b0, 8'h06, 32'd0, 1'b1, 0);
    cap_phase = 1'b1; seen0 = 1'b0; cap_cnt = 0;
    run_until_idle(200, 2);
    cap_phase = 1'b0;
    chk("cap_beats", 64'(cap_cnt), 64'd16);

    // Idle timeout alone, then with requester 1 waiting.
    push(0, 1'b0, 8'h07, 32'd0, 1'b0, 0);
    push(0, 1'b0, 8'h08, 32'd0, 1'b0, 0);
    run_until_idle(50, 2);
    push(0, 1'b0, 8'h09, 32'd0, 1'b0, 0);
    push(0, 1'b0, 8'h0A, 32'd0, 1'b0, 0);
    push(1, 1'b0, 8'h0B, 32'd0, 1'b1, 3);
    run_until_idle(50, 2);

    // Write then read back within one burst.
    push(0, 1'b1, 8'h20, 32'h12345678, 1'b0, 0);
    push(0, 1'b0, 8'h20, 32'd0, 1'b1, 0);
    run_until_idle(50, 2);

    // Randomised bursts from both requesters.
    for (int b = 0; b < 30; b++) begin
      for (int x = 0; x < 2; x++) begin
        int len;
        len = ($urandom_range(0, 7) == 0) ? 20 : int'($urandom_range(1, 8));
        for (int i = 0; i < len; i++)
          push(x, 1'($urandom_range(0, 1)), 8'($urandom_range(0, 31)), $urandom,
               (i == len - 1) && ($urandom_range(0, 7) != 0),
               (i == 0) ? int'($urandom_range(0, 6)) :
               (($urandom_range(0, 9) == 0) ? int'($urandom_range(1, 6)) : 0));
      end
    end
    run_until_idle(20000, 3);

    // Reset in the middle of a write burst from requester 1.
    for (int i = 0; i < 4; i++) push(1, 1'b1, 8'(8'h60 + i), 32'hA0A0_0000 + i, i == 3, 0);
    n = 0;
    while (m_own != 1 && n < 20) begin step(); n++; end
    chk("reach_own1", 64'(m_own), 64'd1);
    step();
    drive();
    #2 RSTn = 1'b0;
    #1;
    chk("mid_rst_memWriteEn", bus.memWriteEn, 1'b0);
    chk("mid_rst_owner", bus.owner, 2'b00);
    chk("mid_rst_ack1", bus.reqAck1, 1'b0);
    chk("mid_rst_rspV0", bus.rspV0, 1'b0);
    chk("mid_rst_rspV1", bus.rspV1, 1'b0);
    @(posedge CLK);
    #1;
    for (int i = 0; i < 4; i++) chk("rst_nowrite", mem[8'h60 + i], ref_mem[8'h60 + i]);
    model_reset();
    drive();
    RSTn = 1'b1;
    repeat (3) step();
    push(1, 1'b0, 8'h61, 32'd0, 1'b1, 0);
    run_until_idle(50, 2);

    chk("left_rsp0", 64'(exp_q[0].size()), 64'd0);
    chk("left_rsp1", 64'(exp_q[1].size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
